// File: rtl/mul_pkg.sv
// Shared encodings for the sequential Booth multiplier family.
package mul_pkg;

    // Controller states: idle, iterating, one-cycle result strobe.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Booth recoding of the pair {A[0], E}.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub on the upper half,
// then an arithmetic right shift of the whole accumulator.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+1:0] acc,
    input  logic               e,
    input  logic [WIDTH:0]     mcand_ext,
    output logic [2*WIDTH+1:0] acc_next,
    output logic               e_next
);

    logic [WIDTH:0] upper;
    logic [WIDTH:0] sum;

    // Recode {A[0],E}, update the upper half (carry-out dropped), then shift.
    always_comb begin
        upper = acc[2*WIDTH+1:WIDTH+1];
        sum   = upper;
        case ({acc[0], e})
            BOOTH_ADD: sum = upper + mcand_ext;
            BOOTH_SUB: sum = upper - mcand_ext;
            default:   sum = upper;
        endcase
        acc_next = {sum[WIDTH], sum, acc[WIDTH:1]};
        e_next   = acc[0];
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-2 Booth multiplier, signed or unsigned per operation.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). The edge
// that samples start=1 latches signed_mode/mcand/mplier and raises busy.
// busy stays high for WIDTH+1 cycles; start seen while busy is ignored.
// done then pulses for exactly one cycle and product is valid from that
// cycle until the next result is written. A start seen in the DONE cycle
// is accepted, so multiplies can run back-to-back.
module seq_booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH+1:0] acc;
    logic               e;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mcand_q;
    logic [2*WIDTH+1:0] acc_step;
    logic               e_step;
    logic               accept;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     mplier_ext;

    // Operand extension to WIDTH+1 bits so unsigned values stay positive.
    always_comb begin
        mcand_ext  = signed_mode ? {mcand[WIDTH-1], mcand}   : {1'b0, mcand};
        mplier_ext = signed_mode ? {mplier[WIDTH-1], mplier} : {1'b0, mplier};
    end

    assign accept = start && (state != ST_RUN);
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .e         (e),
        .mcand_ext (mcand_q),
        .acc_next  (acc_step),
        .e_next    (e_step)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!clear_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic: RUN for WIDTH+1 iterations, DONE for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST_CNT) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, capture product on the last step.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            acc     <= '0;
            e       <= 1'b0;
            cnt     <= '0;
            mcand_q <= '0;
            product <= '0;
        end else if (accept) begin
            acc     <= {{(WIDTH+1){1'b0}}, mplier_ext};
            e       <= 1'b0;
            cnt     <= '0;
            mcand_q <= mcand_ext;
        end else if (state == ST_RUN) begin
            acc <= acc_step;
            e   <= e_step;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) product <= acc_step[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Bench for seq_booth_mul: a 32-bit and an 8-bit instance sharing clock/reset.
module tb_seq_booth_mul;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] mcand32 = '0, mplier32 = '0;
    logic        busy32, done32;
    logic [63:0] product32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  mcand8 = '0, mplier8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;

    seq_booth_mul #(.WIDTH(32)) dut32 (
        .clock(clock), .clear_n(clear_n), .start(start32), .signed_mode(sm32),
        .mcand(mcand32), .mplier(mplier32), .busy(busy32), .done(done32),
        .product(product32)
    );

    seq_booth_mul #(.WIDTH(8)) dut8 (
        .clock(clock), .clear_n(clear_n), .start(start8), .signed_mode(sm8),
        .mcand(mcand8), .mplier(mplier8), .busy(busy8), .done(done8),
        .product(product8)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [15:0] exp_q8[$];
    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm);
        logic [63:0] ea, eb;
        ea = sm ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sm ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Product checks whenever a done pulse is seen.
    always @(negedge clock) begin
        if (mon_en && done32) begin
            if (exp_q.size() == 0) check("spurious_done32", {63'b0, done32}, 64'd0);
            else check("product32", product32, exp_q.pop_front());
        end
        if (mon_en && done8) begin
            if (exp_q8.size() == 0) check("spurious_done8", {63'b0, done8}, 64'd0);
            else check("product8", {48'b0, product8}, {48'b0, exp_q8.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after the accepting edge; returns #1 after the done edge.
    task automatic wait_done32(input string tag, input int poke);
        int lat, bcnt;
        lat  = 0;
        bcnt = busy32 ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (done32) begin lat = k; break; end
            if (busy32) bcnt++;
            if (poke != 0 && k == poke) begin
                start32 = 1'b1; mcand32 = $urandom; mplier32 = $urandom; sm32 = ~sm32;
            end else begin
                start32 = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input logic [63:0] exp, input string tag, input int poke);
        @(negedge clock);
        start32 = 1'b1; mcand32 = a; mplier32 = b; sm32 = sm;
        exp_q.push_back(exp);
        @(posedge clock); #1;
        start32 = 1'b0; mcand32 = $urandom; mplier32 = $urandom; sm32 = ~sm;
        wait_done32(tag, poke);
        @(posedge clock); #1;
        check({tag, "_done_pulse"}, {63'b0, done32}, 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string tag);
        int lat;
        @(negedge clock);
        start8 = 1'b1; mcand8 = a; mplier8 = b; sm8 = sm;
        exp_q8.push_back(exp);
        @(posedge clock); #1;
        start8 = 1'b0; mcand8 = 8'($urandom); mplier8 = 8'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (done8) begin lat = k; break; end
        end
        check({tag, "_latency"}, 64'(lat), 64'd9);
        @(posedge clock); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy32", {63'b0, busy32}, 64'd0);
        check("rst_done32", {63'b0, done32}, 64'd0);
        check("rst_product32", product32, 64'd0);
        check("rst_busy8", {63'b0, busy8}, 64'd0);
        check("rst_product8", {48'b0, product8}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        mon_en  = 1'b1;

        // Directed 32-bit cases.
        op32(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_7xm3", 0);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max", 0);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1", 0);
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minmin", 0);
        op32(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1", 0);

        // start pulsed mid-run must be ignored.
        op32(32'h1234_5678, 32'h0000_0009, 1'b0, 64'h0000_0000_A3D7_0A38, "ignore_start", 10);
        repeat (40) @(posedge clock);
        #1;
        check("ignore_idle_busy", {63'b0, busy32}, 64'd0);

        // Back-to-back: start held in the DONE cycle.
        @(negedge clock);
        start32 = 1'b1; mcand32 = 32'd100; mplier32 = 32'hFFFF_FFF6; sm32 = 1'b1;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FC18);
        @(posedge clock); #1;
        start32 = 1'b0;
        wait_done32("b2b_first", 0);
        start32 = 1'b1; mcand32 = 32'hDEAD_BEEF; mplier32 = 32'h0000_0010; sm32 = 1'b0;
        exp_q.push_back(64'h0000_000D_EADB_EEF0);
        @(posedge clock); #1;
        check("b2b_no_gap_busy", {63'b0, busy32}, 64'd1);
        start32 = 1'b0;
        wait_done32("b2b_second", 0);
        @(posedge clock); #1;

        // Random mixed-mode operations.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h8000_0000;
            op32(ra, rb, rs, model32(ra, rb, rs), "rand", 0);
        end

        // Reset during RUN aborts with no done pulse.
        @(negedge clock);
        start32 = 1'b1; mcand32 = 32'd5; mplier32 = 32'd6; sm32 = 1'b0;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b0;
        @(posedge clock); #1;
        check("abort_busy", {63'b0, busy32}, 64'd0);
        check("abort_done", {63'b0, done32}, 64'd0);
        check("abort_product", product32, 64'd0);
        start32 = 1'b1; mcand32 = 32'd3; mplier32 = 32'd3;
        @(posedge clock); #1;
        check("start_in_reset_busy", {63'b0, busy32}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        start32 = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("abort_no_done_busy", {63'b0, busy32}, 64'd0);
        check("abort_product_held", product32, 64'd0);

        // 8-bit instance.
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_signed");
        op8(8'h80, 8'h7F, 1'b0, 16'h3F80, "w8_unsigned");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_umax");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_minmin");

        repeat (5) @(posedge clock);
        check("leftover32", 64'(exp_q.size()), 64'd0);
        check("leftover8", 64'(exp_q8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_booth_mul.md
Name: seq_booth_mul

Overview:
- Multi-cycle, parametrised radix-2 Booth multiplier for the datapath's MUL/MULU operations.
- Replaces the fully combinational 32-iteration unrolled multiplier with one add/sub-and-shift per clock, which gives shorter critical paths.
- Adds a start/busy/done handshake and a run-time signed/unsigned mode select.
- Product is written to the HI/LO pair by the control unit when done pulses.

Parameters:
- WIDTH, 32: operand width in bits; product is 2*WIDTH bits; legal values are 4 or greater.
- CNT_W, $clog2(WIDTH+2): iteration counter width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  synchronous reset, active-low.
- start  in  1  request a multiply; sampled only when busy=0.
- signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned; sampled with start.
- mcand  in  WIDTH  multiplicand (Y); sampled with start.
- mplier  in  WIDTH  multiplier (X); sampled with start.
- busy  out  1  high while iterations are in progress.
- done  out  1  single-cycle pulse; product valid from this cycle on.
- product  out  2*WIDTH  result; holds until the next accepted start.

Behaviour:
- Reset: when clear_n=0 at a rising edge, the block goes to IDLE. busy=0, done=0, product=0, counter=0, accumulator=0. Reset wins over start in the same cycle. Reset during RUN aborts the operation with no done pulse.
- States are IDLE, RUN and DONE.
- IDLE or DONE, start=1: latch the operands and go to RUN. Operands are extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0.
- Accumulator load: accumulator A (2*WIDTH+2 bits) = {WIDTH+1 zeros, extended multiplier}. Booth extra bit E = 0. Counter = 0.
- Each RUN edge performs one Booth iteration on {A[0],E}:
  - 01: upper half += extended multiplicand.
  - 10: upper half -= extended multiplicand.
  - 00 or 11: no operation.
  - Then E = A[0] and A is arithmetic-shifted right by 1. Counter increments.
- Exit from RUN: after iteration WIDTH+1 (counter reaches WIDTH), go to DONE. Register product = A[2*WIDTH-1:0] and set done=1.
- Latency: done asserts WIDTH+1 clock edges after the edge that accepted start (33 for WIDTH=32). The latency is fixed and does not depend on the data.
- DONE lasts one cycle, then the block goes to IDLE. done=0 in IDLE; product is held.
- busy=1 in RUN only. start while busy=1 is ignored, and the in-flight operands are unaffected.
- start asserted in the DONE cycle is accepted. This allows back-to-back multiplies with no idle cycle.
- Width rule: the internal upper-half add/sub is WIDTH+1 bits wide, with the carry-out discarded. The low 2*WIDTH bits of the result are exact for every operand pair in both modes, including the most-negative × most-negative case.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- mul_pkg holds:
  - the state encoding constants ST_IDLE, ST_RUN, ST_DONE (2 bits);
  - the Booth pair codes BOOTH_ADD=2'b01 and BOOTH_SUB=2'b10.
- One combinational sub-module, booth_step, parametrised by WIDTH:
  - inputs: accumulator, E, extended multiplicand;
  - outputs: next accumulator and next E.
  - It is instantiated once in the RUN datapath and reused by the future radix-4 variant.

Test Plan:
- WIDTH=32, signed: 7 × -3 (0xFFFFFFFD) → after 33 cycles, done pulses 1 cycle and product=0xFFFFFFFF_FFFFFFEB. busy is high exactly 33 cycles.
- WIDTH=32, unsigned: 0xFFFFFFFF × 0xFFFFFFFF → product=0xFFFFFFFE_00000001. Same operands in signed mode → product=0x00000000_00000001.
- WIDTH=32, signed: 0x80000000 × 0x80000000 → product=0x40000000_00000000. 0x80000000 × 0x00000001 → product=0xFFFFFFFF_80000000.
- Start pulsed at cycle 10 of a RUN with different operands → ignored; the original result is produced on schedule. start held high in the DONE cycle → the second result arrives 33 cycles later with no gap.
- clear_n=0 at cycle 15 of a RUN → next cycle busy=0, done=0, product=0, and no done pulse follows. start with clear_n=0 → not accepted.
- WIDTH=8, signed: 0x80 × 0x7F → product=0xC080 with done after 9 cycles. Unsigned mode, same operands → product=0x3F80.
